mult_ctrl_display: RTL and testbench

//  Control/display core of the sequential signed 8x8 multiplier. Holds the shift-add

---
 rtl/mult_ctrl_display_pkg.sv | 29 ++
 rtl/mult_ctrl_display_if.sv | 28 ++
 rtl/mult_ctrl_display_bcd.sv | 26 ++
 rtl/mult_ctrl_display.sv | 100 ++++++++++
 tb/tb_mult_ctrl_display.sv | 132 +++++++++++++
 5 files changed

// File: rtl/mult_ctrl_display_pkg.sv
// Shared types and constants for the multiplier control/display slice:
// sequencer state encoding, datapath widths, scanner digit codes and the
// double-dabble digit correction helper.
package mult_pkg;

   // Product magnitude width and its five-digit BCD rendering.
   localparam int PW   = 14;
   localparam int BCDW = 20;

   // Digit code the 7-segment scanner renders as a minus sign.
   localparam logic [3:0] DIGIT_MINUS = 4'hA;

   // Shift-add sequencer states, 3-bit encoding; codes 6 and 7 are unused.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      TEST  = 3'd2,
      ADD   = 3'd3,
      SHIFT = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Double-dabble correction: a BCD digit of 5 or more gets 3 added
   // so that the following left shift carries into the next digit.
   function automatic logic [3:0] dd_adj(input logic [3:0] digit);
      return (digit >= 4'd5) ? digit + 4'd3 : digit;
   endfunction

endpackage

// File: rtl/mult_ctrl_display_if.sv
// Bundle between the control/display core and its neighbours (debouncer,
// multiplier datapath, 7-segment scanner). master = control core side.
interface mult_ctrl_display_if;
   import mult_pkg::*;

   logic            start;
   logic            zflag;
   logic            lsb_multiplier;
   logic [PW-1:0]   product;
   logic            load;
   logic            reg_en;
   logic            psel;
   logic            shift_en;
   logic            led;
   logic [BCDW-1:0] bcd;
   logic            scan_tick;

   modport master (
      input  start, zflag, lsb_multiplier, product,
      output load, reg_en, psel, shift_en, led, bcd, scan_tick
   );

   modport slave (
      output start, zflag, lsb_multiplier, product,
      input  load, reg_en, psel, shift_en, led, bcd, scan_tick
   );

endinterface

// File: rtl/mult_ctrl_display_bcd.sv
// Purely combinational 14-bit binary to 5-digit BCD converter using the
// shift-and-add-3 (double-dabble) scheme. Valid for 0..16383.
module bcd_dd14
   import mult_pkg::*;
(
   input  logic [PW-1:0]   bin_i,
   output logic [BCDW-1:0] bcd_o
);

   // Working register: BCD digits above, binary operand below.
   logic [PW+BCDW-1:0] sr;

   // Unrolled double-dabble: correct every digit, then shift, once per input bit.
   always_comb begin
      sr = {{BCDW{1'b0}}, bin_i};
      for (int i = 0; i < PW; i++) begin
         for (int d = 0; d < BCDW/4; d++) begin
            sr[PW+4*d +: 4] = dd_adj(sr[PW+4*d +: 4]);
         end
         sr = sr << 1;
      end
   end

   assign bcd_o = sr[PW+BCDW-1:PW];

endmodule

// File: rtl/mult_ctrl_display.sv
// Control/display core of the sequential signed 8x8 multiplier: shift-add
// sequencer FSM driving the datapath strobes and done LED, product magnitude
// to BCD conversion, and the display-scan tick divider.
module mult_ctrl_display
   import mult_pkg::*;
#(
   parameter int DIV = 100_000
)(
   input  logic sys_clk,
   input  logic rst,
   mult_ctrl_display_if.master bus
);

   localparam int          CW   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q, tick_d;

   // Sequencer state register.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic and Moore strobe decode; start is only honoured in
   // IDLE and DONE, and a zero multiplier ends the run before its LSB matters.
   always_comb begin
      state_d      = state_q;
      bus.load     = 1'b0;
      bus.reg_en   = 1'b0;
      bus.psel     = 1'b0;
      bus.shift_en = 1'b0;
      bus.led      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) state_d = LOAD;
         end
         LOAD: begin
            bus.load   = 1'b1;
            bus.reg_en = 1'b1;
            state_d    = TEST;
         end
         TEST: begin
            if (bus.zflag)               state_d = DONE;
            else if (bus.lsb_multiplier) state_d = ADD;
            else                         state_d = SHIFT;
         end
         ADD: begin
            bus.reg_en = 1'b1;
            bus.psel   = 1'b1;
            state_d    = SHIFT;
         end
         SHIFT: begin
            bus.shift_en = 1'b1;
            state_d      = TEST;
         end
         DONE: begin
            bus.led = 1'b1;
            if (bus.start) state_d = LOAD;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Scan divider next-state: count 0..DIV-1 and flag the wrap.
   always_comb begin
      cnt_d  = cnt_q + CW'(1);
      tick_d = 1'b0;
      if (cnt_q == LAST) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end
   end

   // Scan divider registers; tick is high for the cycle after the wrap.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign bus.scan_tick = tick_q;

   bcd_dd14 u_bcd (
      .bin_i (bus.product),
      .bcd_o (bus.bcd)
   );

endmodule

// File: tb/tb_mult_ctrl_display.sv
// Directed self-checking bench for mult_ctrl_display (DIV = 4).
module tb_mult_ctrl_display;
   import mult_pkg::*;

   logic sys_clk = 1'b0;
   logic rst     = 1'b1;
   int   n_assert = 0;
   int   n_fail   = 0;

   mult_ctrl_display_if bus ();

   mult_ctrl_display #(.DIV(4)) dut (
      .sys_clk (sys_clk),
      .rst     (rst),
      .bus     (bus.master)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Outputs packed as {load, reg_en, psel, shift_en, led}.
   task automatic chk_out(input string tag, input logic [4:0] exp_out, input state_t exp_st);
      chk({tag, "_out"}, {27'd0, bus.load, bus.reg_en, bus.psel, bus.shift_en, bus.led}, {27'd0, exp_out});
      chk({tag, "_st"}, {29'd0, dut.state_q}, {29'd0, exp_st});
      $display("step %s: out=%05b state=%0d", tag,
               {bus.load, bus.reg_en, bus.psel, bus.shift_en, bus.led}, dut.state_q);
   endtask

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   localparam logic [4:0] O_IDLE  = 5'b00000;
   localparam logic [4:0] O_LOAD  = 5'b11000;
   localparam logic [4:0] O_TEST  = 5'b00000;
   localparam logic [4:0] O_ADD   = 5'b01100;
   localparam logic [4:0] O_SHIFT = 5'b00010;
   localparam logic [4:0] O_DONE  = 5'b00001;

   // Run of test 2: inputs {start, zflag, lsb} applied before each edge.
   logic [2:0]  r_in  [12];
   state_t      r_st  [12];
   logic [4:0]  r_out [12];

   logic [13:0] p_in  [6];
   logic [19:0] p_bcd [6];

   initial begin
      r_in  = '{3'b100, 3'b100, 3'b001, 3'b100, 3'b000, 3'b100,
                3'b000, 3'b001, 3'b000, 3'b000, 3'b011, 3'b000};
      r_st  = '{LOAD, TEST, ADD, SHIFT, TEST, SHIFT, TEST, ADD, SHIFT, TEST, DONE, DONE};
      r_out = '{O_LOAD, O_TEST, O_ADD, O_SHIFT, O_TEST, O_SHIFT,
                O_TEST, O_ADD, O_SHIFT, O_TEST, O_DONE, O_DONE};
      p_in  = '{14'd0, 14'd9, 14'd9999, 14'd12345, 14'd16129, 14'd16383};
      p_bcd = '{20'h00000, 20'h00009, 20'h09999, 20'h12345, 20'h16129, 20'h16383};

      bus.start          = 1'b0;
      bus.zflag          = 1'b0;
      bus.lsb_multiplier = 1'b0;
      bus.product        = '0;

      // 1/5: reset, then idle with scan tick every 4th cycle after release
      step();
      step();
      chk_out("rst", O_IDLE, IDLE);
      chk("rst_tick", {31'd0, bus.scan_tick}, 32'd0);
      rst = 1'b0;
      for (int n = 1; n <= 10; n++) begin
         step();
         chk_out($sformatf("idle%0d", n), O_IDLE, IDLE);
         chk($sformatf("tick%0d", n), {31'd0, bus.scan_tick}, {31'd0, (n % 4) == 0});
      end

      // 4: BCD conversion, combinational
      for (int k = 0; k < 6; k++) begin
         bus.product = p_in[k];
         #1;
         chk($sformatf("bcd_%0d", p_in[k]), {12'd0, bus.bcd}, {12'd0, p_bcd[k]});
         $display("bcd %0d -> %05h", p_in[k], bus.bcd);
      end

      // 2: full run, lsb 1,0,1 then zflag; start pulses mid-run are ignored
      for (int k = 0; k < 12; k++) begin
         {bus.start, bus.zflag, bus.lsb_multiplier} = r_in[k];
         step();
         chk_out($sformatf("run%0d", k), r_out[k], r_st[k]);
      end
      bus.start = 1'b0; bus.zflag = 1'b0; bus.lsb_multiplier = 1'b0;

      // 3: zero multiplier -> DONE two cycles after LOAD; start in DONE restarts
      bus.start = 1'b1; bus.zflag = 1'b1;
      step(); chk_out("z_load", O_LOAD, LOAD);
      bus.start = 1'b0;
      step(); chk_out("z_test", O_TEST, TEST);
      step(); chk_out("z_done", O_DONE, DONE);
      bus.start = 1'b1;
      step(); chk_out("z_reload", O_LOAD, LOAD);
      bus.start = 1'b0;
      step(); chk_out("z_test2", O_TEST, TEST);
      step(); chk_out("z_done2", O_DONE, DONE);

      // 6: async reset while in ADD
      bus.start = 1'b1; bus.zflag = 1'b0; bus.lsb_multiplier = 1'b1;
      step(); chk_out("r_load", O_LOAD, LOAD);
      bus.start = 1'b0;
      step(); chk_out("r_test", O_TEST, TEST);
      step(); chk_out("r_add", O_ADD, ADD);
      #2 rst = 1'b1;
      #1 chk_out("r_async", O_IDLE, IDLE);
      step();
      rst = 1'b0;
      bus.lsb_multiplier = 1'b0;
      step(); chk_out("r_idle", O_IDLE, IDLE);
      bus.start = 1'b1; bus.zflag = 1'b1;
      step(); chk_out("r2_load", O_LOAD, LOAD);
      bus.start = 1'b0;
      step(); chk_out("r2_test", O_TEST, TEST);
      step(); chk_out("r2_done", O_DONE, DONE);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
